phase_scheduler: RTL
====================

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, 125000000, clk_125M cycles per 1-second tick (>=2).
REQ-002 Parameter RED_SEC, 10, red phase length in ticks (>=1).
REQ-003 Parameter GREEN_SEC, 10, nominal green phase length in ticks (>=1).
REQ-004 Parameter YELLOW_SEC, 3, yellow phase length in ticks (>=1).
REQ-005 Parameter MIN_GREEN_SEC, 3, minimum green ticks before a request may cut green short (1..GREEN_SEC).
REQ-006 clk_125M  input  1  single clock; all logic on its rising edge.
REQ-007 rstn  input  1  reset, asynchronous assert, active-low.
REQ-008 key_value  input  1  debounced key level; 0 = pressed.
REQ-009 key_valid  input  1  one-cycle strobe; key_value is meaningful only when key_valid=1.
REQ-010 red  output  1  red lamp, registered.
REQ-011 green  output  1  green lamp, registered.
REQ-012 yellow  output  1  yellow lamp, registered.
REQ-013 countdown  output  8  ticks remaining in the current phase, registered.
REQ-014 phase_done  output  1  one-cycle pulse in the cycle the phase changes.
REQ-015 req_pending  output  1  pedestrian request latched and not yet served.

Function
REQ-016 Tick counter shall count 0..TICK_DIV-1 and wrap; the internal tick shall be high for one cycle when the counter equals TICK_DIV-1; the counter shall be free-running and shall not restart on phase change.
REQ-017 FSM states shall be RED, GREEN and YELLOW; exactly one of red/green/yellow shall be 1 at all times, matching the state.
REQ-018 On a tick with countdown>1, countdown shall decrement by 1 and the state shall hold.
REQ-019 On a tick with countdown==1: RED->GREEN loading GREEN_SEC; GREEN->YELLOW loading YELLOW_SEC; YELLOW->RED loading RED_SEC.
REQ-020 On a tick in GREEN with req_pending=1 and (GREEN_SEC-countdown+1)>=MIN_GREEN_SEC, the FSM shall go to YELLOW and load YELLOW_SEC regardless of countdown.
REQ-021 State, countdown and lamps shall update in the same cycle as the tick; phase_done shall be 1 in that cycle only, and 0 on ticks that only decrement.
REQ-022 req_pending shall be set in the cycle after key_valid=1 with key_value=0, in any state.
REQ-023 key_valid=1 with key_value=1 (release) shall have no effect.
REQ-024 req_pending shall clear on every GREEN->YELLOW transition, whether by countdown expiry or by request; if a press strobe and that transition occur in the same cycle, clear wins.
REQ-025 A press in RED or YELLOW shall remain pending and shorten the next GREEN per REQ-020.
REQ-026 Repeated presses while pending shall be absorbed; requests shall not be counted.
REQ-027 countdown shall never be 0 outside reset; durations up to 255 shall be supported without overflow.

Reset
REQ-028 With rstn=0, immediately and independent of clk_125M: state=RED, red=1, green=0, yellow=0, countdown=RED_SEC, tick counter=0, phase_done=0, req_pending=0.
REQ-029 Reset asserted mid-phase shall abandon the phase; no phase_done shall be issued for it.
REQ-030 After rstn deasserts, the first tick shall occur TICK_DIV cycles later.

Verification (TICK_DIV=4, RED_SEC=3, GREEN_SEC=5, YELLOW_SEC=2, MIN_GREEN_SEC=2)
REQ-031 Reset release, no key -> red=1, countdown 3,2,1 at cycles 0,4,8; GREEN with countdown=5 and phase_done=1 at cycle 12.
REQ-032 Free run, no key -> repeating RED 12, GREEN 20, YELLOW 8 cycles (40-cycle period); 3 phase_done pulses per period.
REQ-033 Press on the GREEN entry cycle -> req_pending=1 next cycle; YELLOW on the 2nd green tick (countdown 5->4 then ->YELLOW=2); req_pending=0 in the same cycle.
REQ-034 Press during YELLOW -> req_pending held through RED; next GREEN lasts 2 ticks; unpressed GREEN afterwards lasts 5.
REQ-035 key_valid=1 with key_value=1 in GREEN -> req_pending stays 0; GREEN lasts 5 ticks.
REQ-036 rstn pulsed low mid-GREEN (countdown=3, req_pending=1) -> red=1, countdown=3, req_pending=0 with no clock edge; no phase_done pulse.

Source files
------------

// File: rtl/phase_scheduler.sv
// Traffic-light phase scheduler: RED -> GREEN -> YELLOW on a divided 1 s tick,
// with a latched pedestrian request that may cut GREEN short after a minimum green.
module phase_scheduler #(
  parameter int TICK_DIV      = 125000000,
  parameter int RED_SEC       = 10,
  parameter int GREEN_SEC     = 10,
  parameter int YELLOW_SEC    = 3,
  parameter int MIN_GREEN_SEC = 3
) (
  input  logic       clk_125M,
  input  logic       rstn,
  input  logic       key_value,
  input  logic       key_valid,
  output logic       red,
  output logic       green,
  output logic       yellow,
  output logic [7:0] countdown,
  output logic       phase_done,
  output logic       req_pending
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [7:0]       w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_clr_req;
  logic             w_req_nxt;
  logic             w_red_nxt;
  logic             w_green_nxt;
  logic             w_yellow_nxt;
  logic [8:0]       w_elapsed;

  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  // Ticks of GREEN already served including the current one; countdown <= GREEN_SEC here.
  assign w_elapsed = 9'(GREEN_SEC) - {1'b0, countdown} + 9'd1;

  // State register; lamps, countdown and flags are registered alongside it.
  always_ff @(posedge clk_125M or negedge rstn) begin
    if (!rstn) begin
      r_tick_cnt  <= '0;
      r_state     <= S_RED;
      countdown   <= 8'(RED_SEC);
      phase_done  <= 1'b0;
      req_pending <= 1'b0;
      red         <= 1'b1;
      green       <= 1'b0;
      yellow      <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_state     <= w_state_nxt;
      countdown   <= w_cnt_nxt;
      phase_done  <= w_done_nxt;
      req_pending <= w_req_nxt;
      red         <= w_red_nxt;
      green       <= w_green_nxt;
      yellow      <= w_yellow_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = countdown;
    w_done_nxt  = 1'b0;
    w_clr_req   = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_RED: begin
          if (countdown == 8'd1) begin
            w_state_nxt = S_GREEN;
            w_cnt_nxt   = 8'(GREEN_SEC);
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = countdown - 8'd1;
          end
        end
        S_GREEN: begin
          if (countdown == 8'd1 || (req_pending && w_elapsed >= 9'(MIN_GREEN_SEC))) begin
            w_state_nxt = S_YELLOW;
            w_cnt_nxt   = 8'(YELLOW_SEC);
            w_done_nxt  = 1'b1;
            w_clr_req   = 1'b1;
          end else begin
            w_cnt_nxt = countdown - 8'd1;
          end
        end
        S_YELLOW: begin
          if (countdown == 8'd1) begin
            w_state_nxt = S_RED;
            w_cnt_nxt   = 8'(RED_SEC);
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = countdown - 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_RED;
          w_cnt_nxt   = 8'(RED_SEC);
          w_done_nxt  = 1'b1;
        end
      endcase
    end
  end

  // Serving the request on GREEN->YELLOW takes priority over a simultaneous press.
  always_comb begin
    w_red_nxt    = (w_state_nxt == S_RED);
    w_green_nxt  = (w_state_nxt == S_GREEN);
    w_yellow_nxt = (w_state_nxt == S_YELLOW);
    w_req_nxt    = req_pending;
    if (w_clr_req) begin
      w_req_nxt = 1'b0;
    end else if (key_valid && !key_value) begin
      w_req_nxt = 1'b1;
    end
  end

endmodule
